// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: x1..x31 register file with per-register in-flight writer counters.
// Optional REGFILE_WB_BYPASS_EN: same-cycle writeback-to-read forwarding and busy release.
module regfile_scoreboard #(
  parameter int XLEN         = 32,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      a1_d,
  input  logic [4:0]      a2_d,
  output logic [XLEN-1:0] rd1_d,
  output logic [XLEN-1:0] rd2_d,
  output logic            busy1_d,
  output logic            busy2_d,
  input  logic            issue_d,
  input  logic [4:0]      rd_d,
  output logic            issue_ready_d,
  input  logic            retire_w,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] wb_result_w
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [XLEN-1:0] regs [32];
  logic [CW-1:0]   cnt [32];
  logic [31:1]     inc, dec;
  logic            wr_en;
  assign wr_en = reg_write_w && rd_w != 5'd0;
  // A retire of the same register frees a slot, so a full counter can still accept the claim.
  assign issue_ready_d = !(issue_d && rd_d != 5'd0 && cnt[rd_d] == CMAX && !(retire_w && rd_w == rd_d));
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < 32; r++) begin
      inc[r] = issue_d && issue_ready_d && rd_d == 5'(r);
      dec[r] = retire_w && rd_w == 5'(r) && cnt[r] != '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wr_en) regs[rd_w] <= wb_result_w;
      for (int r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + ONE;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - ONE;
      end
    end
  end
  always_comb begin
    rd1_d   = a1_d == 5'd0 ? '0 : (BYPASS && wr_en && rd_w == a1_d) ? wb_result_w : regs[a1_d];
    rd2_d   = a2_d == 5'd0 ? '0 : (BYPASS && wr_en && rd_w == a2_d) ? wb_result_w : regs[a2_d];
    busy1_d = a1_d != 5'd0 && cnt[a1_d] != '0 && !(BYPASS && retire_w && rd_w == a1_d && cnt[a1_d] == ONE);
    busy2_d = a2_d != 5'd0 && cnt[a2_d] != '0 && !(BYPASS && retire_w && rd_w == a2_d && cnt[a2_d] == ONE);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: table-driven per-cycle vectors checked through an expected-result queue.
module tb_regfile_scoreboard;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic        rst, iss, ret, wr;
    logic [4:0]  a1, a2, rdd, rdw;
    logic [31:0] wb;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2, e_rdy;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] a1_d = '0, a2_d = '0, rd_d = '0, rd_w = '0;
  logic [31:0] rd1_d, rd2_d, wb_result_w = '0;
  logic busy1_d, busy2_d, issue_d = 1'b0, issue_ready_d, retire_w = 1'b0, reg_write_w = 1'b0;
  int n_vec = 0, n_err = 0;
  vec_t vecs[$];
  vec_t q[$];
  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .a1_d(a1_d), .a2_d(a2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .busy1_d(busy1_d), .busy2_d(busy2_d), .issue_d(issue_d), .rd_d(rd_d),
    .issue_ready_d(issue_ready_d), .retire_w(retire_w), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .wb_result_w(wb_result_w)
  );
  always #5 clk = ~clk;
  task automatic add(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                     input logic iss, input logic [4:0] rdd, input logic ret, input logic wr,
                     input logic [4:0] rdw, input logic [31:0] wb, input logic [31:0] e_rd1,
                     input logic [31:0] e_rd2, input logic e_b1, input logic e_b2, input logic e_rdy);
    vec_t v;
    v.rst = rst; v.a1 = a1; v.a2 = a2; v.iss = iss; v.rdd = rdd; v.ret = ret; v.wr = wr;
    v.rdw = rdw; v.wb = wb; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_rdy = e_rdy;
    vecs.push_back(v);
  endtask
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask
  initial begin
    //   rst a1 a2 iss rdd ret wr rdw wb            e_rd1                    e_rd2         b1         b2 rdy
    add(0, 5, 0, 0, 0, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 7, 0, 0, 0, 1, 1, 7, 32'hDEADBEEF, BYP ? 32'hDEADBEEF : 0,   0,            0,         0, 1);
    add(0, 7, 0, 0, 0, 1, 1, 0, 32'h1234,     32'hDEADBEEF,             0,            0,         0, 1);
    add(0, 0, 7, 0, 0, 0, 0, 0, 0,            0,                        32'hDEADBEEF, 0,         0, 1);
    add(0, 3, 0, 1, 3, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 0, 0,            0,                        0,            1,         0, 1);
    add(0, 3, 0, 0, 0, 1, 1, 3, 32'h55,       BYP ? 32'h55 : 0,         0,            !BYP,      0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 0, 0,            32'h55,                   0,            0,         0, 1);
    add(0, 9, 0, 1, 9, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 9, 0, 1, 9, 0, 0, 0, 0,            0,                        0,            1,         0, 1);
    add(0, 0, 9, 1, 9, 0, 0, 0, 0,            0,                        0,            0,         1, 1);
    add(0, 9, 0, 1, 9, 0, 0, 0, 0,            0,                        0,            1,         0, 0);
    add(0, 9, 0, 1, 9, 1, 1, 9, 32'h99,       BYP ? 32'h99 : 0,         0,            1,         0, 1);
    add(0, 9, 0, 1, 9, 0, 0, 0, 0,            32'h99,                   0,            1,         0, 0);
    add(0, 9, 0, 0, 0, 1, 0, 9, 32'hF0,       32'h99,                   0,            1,         0, 1);
    add(0, 9, 0, 0, 0, 1, 0, 9, 32'hF1,       32'h99,                   0,            1,         0, 1);
    add(0, 9, 0, 0, 0, 1, 0, 9, 32'hF2,       32'h99,                   0,            !BYP,      0, 1);
    add(0, 9, 0, 0, 0, 0, 0, 0, 0,            32'h99,                   0,            0,         0, 1);
    add(0, 4, 0, 1, 4, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 4, 0, 0, 0, 1, 0, 4, 32'hAAAA,     0,                        0,            !BYP,      0, 1);
    add(0, 4, 0, 0, 0, 1, 0, 4, 32'hBBBB,     0,                        0,            0,         0, 1);
    add(0, 4, 0, 1, 4, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 4, 0, 0, 0, 0, 0, 0, 0,            0,                        0,            1,         0, 1);
    add(0, 2, 0, 1, 2, 0, 1, 2, 32'h22,       BYP ? 32'h22 : 0,         0,            0,         0, 1);
    add(0, 2, 6, 1, 6, 0, 0, 0, 0,            32'h22,                   0,            1,         0, 1);
    add(1, 2, 6, 1, 2, 0, 1, 2, 32'h77,       BYP ? 32'h77 : 32'h22,    0,            1,         1, 1);
    add(0, 2, 6, 0, 0, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 4, 0, 1, 0, 1, 0, 0, 0,            0,                        0,            0,         0, 1);
    add(0, 0, 4, 0, 0, 0, 0, 0, 0,            0,                        0,            0,         0, 1);
    // Hand-written reset sequence: inputs idle, check the post-reset state.
    @(posedge clk);
    #1 reset = 1'b0; a1_d = 5'd5;
    @(negedge clk);
    n_vec++;
    chk("reset_rd1", -1, rd1_d, 0);
    chk("reset_rd2", -1, rd2_d, 0);
    chk("reset_busy", -1, {30'd0, busy1_d, busy2_d}, 0);
    chk("reset_ready", -1, {31'd0, issue_ready_d}, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst; a1_d = vecs[i].a1; a2_d = vecs[i].a2; issue_d = vecs[i].iss;
      rd_d = vecs[i].rdd; retire_w = vecs[i].ret; reg_write_w = vecs[i].wr; rd_w = vecs[i].rdw;
      wb_result_w = vecs[i].wb;
      q.push_back(vecs[i]);
      @(negedge clk);
      begin
        vec_t e;
        e = q.pop_front();
        n_vec++;
        chk("rd1", i, rd1_d, e.e_rd1);
        chk("rd2", i, rd2_d, e.e_rd2);
        chk("busy1", i, {31'd0, busy1_d}, {31'd0, e.e_b1});
        chk("busy2", i, {31'd0, busy2_d}, {31'd0, e.e_b2});
        chk("issue_ready", i, {31'd0, issue_ready_d}, {31'd0, e.e_rdy});
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
